sdram_arbit: RTL and testbench
==============================

SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 Parameter CMD_NOP, default 4'b0111, the command code {CS_n,RAS_n,CAS_n,WE_n} driven when no requester owns the bus.
REQ-002 Parameter ADDR_W, default 12, the SDRAM address width.
REQ-003 clk  input  1  single system clock; all logic SHALL be rising-edge clk.
REQ-004 rst  input  1  synchronous, active-high reset; one clock, reset synchronous active-high.
REQ-005 flag_init_end  input  1  init sequencer done; level, stays high once set.
REQ-006 init_cmd / init_addr  input  4 / ADDR_W  init sequencer command and address.
REQ-007 ref_req / ref_end  input  1 / 1  refresh request level; refresh done pulse.
REQ-008 ref_cmd / ref_addr  input  4 / ADDR_W  refresh engine command and address.
REQ-009 wr_req / wr_end  input  1 / 1  write request level; write burst done pulse.
REQ-010 wr_cmd / wr_addr  input  4 / ADDR_W  write engine command and address.
REQ-011 rd_req / rd_end  input  1 / 1  read request level; read burst done pulse.
REQ-012 rd_cmd / rd_addr  input  4 / ADDR_W  read engine command and address.
REQ-013 ref_en / wr_en / rd_en  output  1 each  registered one-cycle grant pulses.
REQ-014 sdram_cmd / sdram_addr  output  4 / ADDR_W  muxed command and address to the SDRAM pins.
REQ-015 busy  output  1  high in any state other than ARBIT.

Function
REQ-016 The block SHALL hold a registered FSM with states INIT, ARBIT, AREF, WRITE, READ.
REQ-017 INIT -> ARBIT on the first rising clk edge where flag_init_end=1; otherwise stay in INIT.
REQ-018 In ARBIT, grant priority SHALL be ref_req > write/read; exactly one state is entered per edge.
REQ-019 Write vs read tie (wr_req=rd_req=1, ref_req=0): grant the one not granted last; a last_grant register updates on every WRITE or READ entry.
REQ-020 Single requester, no conflict: grant that requester; no requests: stay in ARBIT.
REQ-021 On the edge entering AREF/WRITE/READ, the matching *_en SHALL be 1 for exactly that next cycle, then 0.
REQ-022 AREF/WRITE/READ -> ARBIT on the edge where the matching *_end=1; *_end of a non-owner SHALL be ignored.
REQ-023 Minimum residence in a granted state SHALL be 1 cycle; a new grant SHALL not be issued earlier than the edge after the return to ARBIT.
REQ-024 A request dropped before a grant SHALL produce no grant; requests arriving while busy SHALL wait (level-held by requesters).
REQ-025 sdram_cmd/sdram_addr SHALL be combinational from state: INIT->init_*, AREF->ref_*, WRITE->wr_*, READ->rd_*, ARBIT->CMD_NOP and all-zero address.
REQ-026 busy SHALL be combinational: 0 in ARBIT, 1 otherwise.
REQ-027 A ref_req asserted during WRITE or READ SHALL be granted immediately on the return to ARBIT, ahead of pending wr_req/rd_req.

Reset
REQ-028 With rst=1 at a rising edge: state=INIT, ref_en=wr_en=rd_en=0, last_grant=READ (first tie goes to write).
REQ-029 Reset asserted mid-burst SHALL abandon the grant at the next edge; sdram_cmd then follows init_cmd.
REQ-030 After reset release the FSM SHALL remain in INIT until flag_init_end=1, regardless of any *_req.

Verification
REQ-031 Init gating: rst pulse, wr_req=1, flag_init_end low 20 cycles -> no wr_en, sdram_cmd==init_cmd; flag_init_end high -> wr_en pulse 2 edges later.
REQ-032 Priority: in ARBIT, ref_req=wr_req=rd_req=1 same cycle -> ref_en one cycle, sdram_cmd==ref_cmd until ref_end; then wr_en next.
REQ-033 Alternation: wr_req=rd_req=1 held, each burst ended 4 cycles after grant -> grants WRITE, READ, WRITE, READ; each *_en exactly 1 cycle wide.
REQ-034 Foreign end: in WRITE, pulse rd_end and ref_end -> state stays WRITE, sdram_cmd==wr_cmd; wr_end -> ARBIT, sdram_cmd==4'b0111, sdram_addr==0.
REQ-035 Refresh pre-emption: ref_req raised mid-READ while wr_req=1 -> on rd_end, AREF granted before WRITE.
REQ-036 Mid-burst reset: rst=1 during WRITE -> next cycle busy=1, state INIT, wr_en=0, sdram_cmd==init_cmd.

Source files
------------

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: owns the command/address pins for init, refresh, write and read engines.
// Refresh wins over write/read; simultaneous write/read requests alternate.
module sdram_arbit #(
    parameter logic [3:0] CMD_NOP = 4'b0111,
    parameter int         ADDR_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ref_req,
    input  logic              ref_end,
    input  logic [3:0]        ref_cmd,
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              ref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              busy
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_ARBIT = 3'd1;
    localparam logic [2:0] S_AREF  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    logic [2:0] state_q, state_d;
    logic       last_wr_q, last_wr_d;
    logic       ref_en_q, ref_en_d;
    logic       wr_en_q, wr_en_d;
    logic       rd_en_q, rd_en_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (flag_init_end) state_d = S_ARBIT;
            S_ARBIT: begin
                if (ref_req)
                    state_d = S_AREF;
                else if (wr_req && rd_req)
                    state_d = last_wr_q ? S_READ : S_WRITE;
                else if (wr_req)
                    state_d = S_WRITE;
                else if (rd_req)
                    state_d = S_READ;
            end
            S_AREF:  if (ref_end) state_d = S_ARBIT;
            S_WRITE: if (wr_end)  state_d = S_ARBIT;
            S_READ:  if (rd_end)  state_d = S_ARBIT;
            default: state_d = S_INIT;
        endcase
    end

    // Grant pulses fire only on the ARBIT exit edge, so they are one cycle wide by construction.
    always_comb begin
        ref_en_d  = (state_q == S_ARBIT) && (state_d == S_AREF);
        wr_en_d   = (state_q == S_ARBIT) && (state_d == S_WRITE);
        rd_en_d   = (state_q == S_ARBIT) && (state_d == S_READ);
        last_wr_d = last_wr_q;
        if (wr_en_d)
            last_wr_d = 1'b1;
        else if (rd_en_d)
            last_wr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_INIT;
            last_wr_q <= 1'b0;
            ref_en_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            ref_en_q  <= ref_en_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
        end
    end

    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        case (state_q)
            S_INIT:  begin sdram_cmd = init_cmd; sdram_addr = init_addr; end
            S_AREF:  begin sdram_cmd = ref_cmd;  sdram_addr = ref_addr;  end
            S_WRITE: begin sdram_cmd = wr_cmd;   sdram_addr = wr_addr;   end
            S_READ:  begin sdram_cmd = rd_cmd;   sdram_addr = rd_addr;   end
            default: begin sdram_cmd = CMD_NOP;  sdram_addr = '0;        end
        endcase
    end

    assign busy   = (state_q != S_ARBIT);
    assign ref_en = ref_en_q;
    assign wr_en  = wr_en_q;
    assign rd_en  = rd_en_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed table-driven bench for sdram_arbit, plus a write/read alternation sequence.
module tb_sdram_arbit;

    localparam logic [3:0]  C_INIT = 4'b0001;
    localparam logic [3:0]  C_REF  = 4'b0010;
    localparam logic [3:0]  C_WR   = 4'b0100;
    localparam logic [3:0]  C_RD   = 4'b0101;
    localparam logic [3:0]  C_NOP  = 4'b0111;
    localparam logic [11:0] A_INIT = 12'h111;
    localparam logic [11:0] A_REF  = 12'h222;
    localparam logic [11:0] A_WR   = 12'h333;
    localparam logic [11:0] A_RD   = 12'h444;

    localparam int O_INIT = 0, O_NOP = 1, O_REF = 2, O_WR = 3, O_RD = 4;

    logic clk = 1'b0;
    logic rst, flag_init_end;
    logic ref_req, ref_end, wr_req, wr_end, rd_req, rd_end;
    logic ref_en, wr_en, rd_en, busy;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    sdram_arbit #(.CMD_NOP(4'b0111), .ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .flag_init_end(flag_init_end),
        .init_cmd(C_INIT), .init_addr(A_INIT),
        .ref_req(ref_req), .ref_end(ref_end), .ref_cmd(C_REF), .ref_addr(A_REF),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(C_WR), .wr_addr(A_WR),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(C_RD), .rd_addr(A_RD),
        .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .busy(busy)
    );

    // in = {rst, flag, ref_req, wr_req, rd_req, ref_end, wr_end, rd_end}
    // en = {ref_en, wr_en, rd_en, busy}; own selects the expected pin owner
    typedef struct {
        logic [7:0] in;
        logic [3:0] en;
        int         own;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [7:0] in, input logic [3:0] en, input int own);
        vec_t v;
        v.in  = in;
        v.en  = en;
        v.own = own;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    endtask

    task automatic drive(input logic [7:0] in);
        {rst, flag_init_end, ref_req, wr_req, rd_req, ref_end, wr_end, rd_end} = in;
    endtask

    task automatic check_out(input int idx, input logic [3:0] en, input int own);
        logic [3:0]  ec;
        logic [11:0] ea;
        case (own)
            O_INIT:  begin ec = C_INIT; ea = A_INIT; end
            O_REF:   begin ec = C_REF;  ea = A_REF;  end
            O_WR:    begin ec = C_WR;   ea = A_WR;   end
            O_RD:    begin ec = C_RD;   ea = A_RD;   end
            default: begin ec = C_NOP;  ea = 12'h000; end
        endcase
        chk("ref_en", idx, {31'd0, ref_en}, {31'd0, en[3]});
        chk("wr_en",  idx, {31'd0, wr_en},  {31'd0, en[2]});
        chk("rd_en",  idx, {31'd0, rd_en},  {31'd0, en[1]});
        chk("busy",   idx, {31'd0, busy},   {31'd0, en[0]});
        chk("cmd",    idx, {28'd0, sdram_cmd},  {28'd0, ec});
        chk("addr",   idx, {20'd0, sdram_addr}, {20'd0, ea});
    endtask

    initial begin
        drive(8'b1000_0000);

        //     rst/flag/rq/wq/dq/re/we/de   ref/wr/rd/busy  owner
        add(8'b1_0_0_1_0_000, 4'b0001, O_INIT);  // 0 reset with wr_req pending
        add(8'b0_0_0_1_0_000, 4'b0001, O_INIT);  // 1 init gating
        add(8'b0_0_0_1_0_000, 4'b0001, O_INIT);  // 2
        add(8'b0_1_0_1_0_000, 4'b0000, O_NOP);   // 3 init done -> ARBIT
        add(8'b0_1_0_1_0_000, 4'b0101, O_WR);    // 4 wr granted
        add(8'b0_1_0_1_0_101, 4'b0001, O_WR);    // 5 foreign ref_end/rd_end ignored
        add(8'b0_1_0_0_0_010, 4'b0000, O_NOP);   // 6 wr_end -> ARBIT
        add(8'b0_1_0_0_0_000, 4'b0000, O_NOP);   // 7 idle
        add(8'b0_1_1_1_1_000, 4'b1001, O_REF);   // 8 refresh wins
        add(8'b0_1_1_1_1_000, 4'b0001, O_REF);   // 9 ref_en one cycle only
        add(8'b0_1_0_1_1_100, 4'b0000, O_NOP);   // 10 ref_end
        add(8'b0_1_0_1_1_000, 4'b0011, O_RD);    // 11 tie after write -> read
        add(8'b0_1_1_1_1_000, 4'b0001, O_RD);    // 12 ref_req raised mid-read
        add(8'b0_1_1_1_0_001, 4'b0000, O_NOP);   // 13 rd_end
        add(8'b0_1_1_1_0_000, 4'b1001, O_REF);   // 14 refresh ahead of write
        add(8'b0_1_0_1_1_100, 4'b0000, O_NOP);   // 15 ref_end
        add(8'b0_1_0_1_1_000, 4'b0101, O_WR);    // 16 tie after read -> write
        add(8'b0_1_0_1_0_000, 4'b0001, O_WR);    // 17 mid-burst
        add(8'b1_1_0_1_0_000, 4'b0001, O_INIT);  // 18 reset abandons write
        add(8'b0_0_0_0_1_000, 4'b0001, O_INIT);  // 19 stays in INIT despite rd_req
        add(8'b0_1_0_0_1_000, 4'b0000, O_NOP);   // 20
        add(8'b0_1_0_0_1_000, 4'b0011, O_RD);    // 21 single read requester
        add(8'b0_1_0_0_0_001, 4'b0000, O_NOP);   // 22 rd_end

        @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].in);
            @(posedge clk);
            #1;
            check_out(i, vq[i].en, vq[i].own);
        end

        // Alternation: last grant was READ, so WRITE, READ, WRITE, READ with 4-cycle bursts.
        for (int b = 0; b < 4; b++) begin
            logic is_wr;
            is_wr = (b % 2 == 0);
            drive(8'b0_1_0_1_1_000);
            @(posedge clk);
            #1;
            check_out(100 + b, is_wr ? 4'b0101 : 4'b0011, is_wr ? O_WR : O_RD);
            for (int k = 0; k < 3; k++) begin
                @(posedge clk);
                #1;
                check_out(200 + 10 * b + k, 4'b0001, is_wr ? O_WR : O_RD);
            end
            drive(is_wr ? 8'b0_1_0_1_1_010 : 8'b0_1_0_1_1_001);
            @(posedge clk);
            #1;
            check_out(300 + b, 4'b0000, O_NOP);
        end

        drive(8'b0_1_0_0_0_000);
        @(posedge clk);
        #1;
        check_out(400, 4'b0000, O_NOP);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
